// File: rtl/endgame_pkg.sv
// Shared encodings and constants for the endgame round controller.
package endgame_pkg;

  localparam int unsigned SEC_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WIN  = 2'd2,
    ST_LOSE = 2'd3
  } state_e;

  localparam logic [9:0] LED_OFF     = 10'h000;
  localparam logic [9:0] LED_WIN     = 10'h3FF;
  localparam logic [9:0] LED_BLINK_A = 10'h2AA;
  localparam logic [9:0] LED_BLINK_B = 10'h155;

endpackage

// File: rtl/endgame_controller_tick_divider.sv
// Free-running divider: one-cycle tick every DIV cycles, held at phase zero while clear is high.
module tick_divider #(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = !clear && (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/endgame_controller.sv
// Endgame round controller: enables PIN entry, counts down seconds, latches WIN or LOSE
// and drives the result LED pattern.
module endgame_controller
  import endgame_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned TIME_LIMIT = 30,
  parameter int unsigned BLINK_HALF = CLK_HZ / 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             auth_done,
  output logic             show_pin,
  output logic             win,
  output logic             lose,
  output logic [SEC_W-1:0] seconds_left,
  output logic [9:0]       result_led
);

  localparam logic [SEC_W-1:0] SecInit = SEC_W'(TIME_LIMIT);

  state_e           state_q, state_d;
  logic             start_q;
  logic             show_pin_q, show_pin_d;
  logic             win_q, win_d;
  logic             lose_q, lose_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic [9:0]       led_q, led_d;
  logic             start_rise;
  logic             sec_tick;
  logic             blink_tick;

  assign start_rise = start & ~start_q;

  // Both dividers sit at phase zero outside their state, so each state entry starts a fresh period.
  tick_divider #(
    .DIV (CLK_HZ)
  ) u_sec_div (
    .clk    (clk),
    .resetn (resetn),
    .clear  (state_q != ST_RUN),
    .tick   (sec_tick)
  );

  tick_divider #(
    .DIV (BLINK_HALF)
  ) u_blink_div (
    .clk    (clk),
    .resetn (resetn),
    .clear  (state_q != ST_LOSE),
    .tick   (blink_tick)
  );

  always_comb begin
    state_d    = state_q;
    show_pin_d = show_pin_q;
    win_d      = win_q;
    lose_d     = lose_q;
    sec_d      = sec_q;
    led_d      = led_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          state_d    = ST_RUN;
          show_pin_d = 1'b1;
          sec_d      = SecInit;
        end
      end
      ST_RUN: begin
        // Authentication beats a coincident final tick.
        if (auth_done) begin
          state_d    = ST_WIN;
          show_pin_d = 1'b0;
          win_d      = 1'b1;
          led_d      = LED_WIN;
        end else if (sec_tick) begin
          if (sec_q <= SEC_W'(1)) begin
            state_d    = ST_LOSE;
            show_pin_d = 1'b0;
            lose_d     = 1'b1;
            sec_d      = '0;
            led_d      = LED_BLINK_A;
          end else begin
            sec_d = sec_q - SEC_W'(1);
          end
        end
      end
      ST_WIN, ST_LOSE: begin
        if (start_rise) begin
          state_d    = ST_RUN;
          show_pin_d = 1'b1;
          win_d      = 1'b0;
          lose_d     = 1'b0;
          sec_d      = SecInit;
          led_d      = LED_OFF;
        end else if (state_q == ST_LOSE && blink_tick) begin
          led_d = (led_q == LED_BLINK_A) ? LED_BLINK_B : LED_BLINK_A;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      start_q    <= 1'b0;
      show_pin_q <= 1'b0;
      win_q      <= 1'b0;
      lose_q     <= 1'b0;
      sec_q      <= '0;
      led_q      <= LED_OFF;
    end else begin
      state_q    <= state_d;
      start_q    <= start;
      show_pin_q <= show_pin_d;
      win_q      <= win_d;
      lose_q     <= lose_d;
      sec_q      <= sec_d;
      led_q      <= led_d;
    end
  end

  assign show_pin     = show_pin_q;
  assign win          = win_q;
  assign lose         = lose_q;
  assign seconds_left = sec_q;
  assign result_led   = led_q;

endmodule

// File: tb/tb_endgame_controller.sv
// Scoreboard bench: a round-level reference model queues expected outputs per cycle,
// a negedge monitor pops and compares them against the controller.
module tb_endgame_controller;

  localparam int CLK = 10;
  localparam int TL  = 3;
  localparam int BH  = 4;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_WIN  = 2;
  localparam int M_LOSE = 3;

  typedef struct packed {
    logic       show;
    logic       win;
    logic       lose;
    logic [5:0] sl;
    logic [9:0] led;
  } obs_t;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic       auth_done;
  logic       show_pin;
  logic       win;
  logic       lose;
  logic [5:0] seconds_left;
  logic [9:0] result_led;

  int   n_cmp = 0;
  int   n_err = 0;
  obs_t exp_q[$];
  obs_t mon_e, mon_a;

  // Reference model state: round phase, cycles spent in RUN, cycles spent in LOSE.
  int m_mode;
  int m_elapsed;
  int m_lose_cyc;
  int m_win_sec;
  bit m_start_prev;

  endgame_controller #(
    .CLK_HZ     (CLK),
    .TIME_LIMIT (TL),
    .BLINK_HALF (BH)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .auth_done    (auth_done),
    .show_pin     (show_pin),
    .win          (win),
    .lose         (lose),
    .seconds_left (seconds_left),
    .result_led   (result_led)
  );

  always #5 clk = ~clk;

  function automatic obs_t model_out();
    obs_t o;
    o = '0;
    case (m_mode)
      M_RUN: begin
        o.show = 1'b1;
        o.sl   = 6'(TL - m_elapsed / CLK);
      end
      M_WIN: begin
        o.win = 1'b1;
        o.sl  = 6'(m_win_sec);
        o.led = 10'h3FF;
      end
      M_LOSE: begin
        o.lose = 1'b1;
        o.led  = ((m_lose_cyc / BH) % 2 == 0) ? 10'h2AA : 10'h155;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

  task automatic model_reset();
    m_mode       = M_IDLE;
    m_elapsed    = 0;
    m_lose_cyc   = 0;
    m_win_sec    = 0;
    m_start_prev = 1'b0;
  endtask

  task automatic model_step(input bit s, input bit a);
    bit rise;
    rise         = s && !m_start_prev;
    m_start_prev = s;
    case (m_mode)
      M_IDLE: if (rise) begin m_mode = M_RUN; m_elapsed = 0; end
      M_RUN: begin
        if (a) begin
          m_win_sec = TL - m_elapsed / CLK;
          m_mode    = M_WIN;
        end else if (m_elapsed + 1 == TL * CLK) begin
          m_mode     = M_LOSE;
          m_lose_cyc = 0;
        end else begin
          m_elapsed++;
        end
      end
      M_WIN: if (rise) begin m_mode = M_RUN; m_elapsed = 0; end
      M_LOSE: begin
        if (rise) begin m_mode = M_RUN; m_elapsed = 0; end
        else m_lose_cyc++;
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  task automatic cycle(input bit s, input bit a);
    #1;
    start     = s;
    auth_done = a;
    @(posedge clk);
    model_step(s, a);
    exp_q.push_back(model_out());
  endtask

  task automatic reset_cycle();
    #1;
    resetn = 1'b0;
    @(posedge clk);
    model_reset();
    exp_q.push_back(model_out());
  endtask

  task automatic check(input string name, input int got, input int req);
    n_cmp++;
    if (got != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = {show_pin, win, lose, seconds_left, result_led};
      n_cmp++;
      if (mon_a !== mon_e) begin
        n_err++;
        $display("FAIL outputs @%0t: got show=%b win=%b lose=%b sec=%0d led=%h, required show=%b win=%b lose=%b sec=%0d led=%h",
                 $time, mon_a.show, mon_a.win, mon_a.lose, mon_a.sl, mon_a.led,
                 mon_e.show, mon_e.win, mon_e.lose, mon_e.sl, mon_e.led);
      end
    end
  end

  initial begin
    resetn    = 1'b0;
    start     = 1'b0;
    auth_done = 1'b0;
    model_reset();

    // Reset, then idle with start low.
    repeat (3) reset_cycle();
    #1 resetn = 1'b1;
    repeat (20) cycle(1'b0, 1'b0);

    // Win: auth_done sampled on cycle 15 of RUN; auth_done in WIN is ignored.
    cycle(1'b1, 1'b0);
    repeat (15) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    for (int k = 0; k < 6; k++) cycle(1'b0, bit'(k % 2));

    // Restart from WIN, ignored start edge mid-RUN, timeout and blink (auth in LOSE ignored).
    cycle(1'b1, 1'b0);
    repeat (4) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    repeat (40) cycle(1'b0, 1'b0);
    repeat (3) cycle(1'b0, 1'b1);
    repeat (4) cycle(1'b0, 1'b0);

    // Restart from LOSE, then auth_done on the cycle of the final tick.
    cycle(1'b1, 1'b0);
    repeat (29) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    repeat (3) cycle(1'b0, 1'b0);

    // Asynchronous reset between edges with seconds_left at 2.
    cycle(1'b1, 1'b0);
    repeat (12) cycle(1'b0, 1'b0);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("async_show_pin", int'(show_pin), 0);
    check("async_seconds_left", int'(seconds_left), 0);
    check("async_win_lose", int'({win, lose}), 0);
    model_reset();
    repeat (2) reset_cycle();
    #1 resetn = 1'b1;
    repeat (10) cycle(1'b0, bit'($urandom_range(0, 1)));
    cycle(1'b1, 1'b0);
    repeat (5) cycle(1'b0, 1'b0);

    // Randomized rounds.
    for (int i = 0; i < 600; i++) begin
      cycle(bit'($urandom_range(0, 7) == 0), bit'($urandom_range(0, 39) == 0));
    end

    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
